// File: rtl/stack_return_unit.sv
// Pops a saved return frame after RET/RTI and restores the PC (and flags for RTI).
// Optional macro RET_TIMEOUT_EN adds a bounded READ wait and a one-cycle ERR state.
module stack_return_unit #(
   parameter int TIMEOUT = 15,
   parameter int PC_BITS = 28
) (
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_isRet,
   input  logic        i_isRti,
   input  logic [31:0] i_sp,
   input  logic        i_memValid,
   input  logic [31:0] i_memData,
   output logic        o_memRead,
   output logic        o_en32,
   output logic [31:0] o_address,
   output logic        o_spPop,
   output logic        o_stall,
   output logic        o_pcLoad,
   output logic [31:0] o_pc,
   output logic        o_flagsLoad,
   output logic [3:0]  o_flags,
   output logic        o_flush,
   output logic        o_timeout
);

`ifdef RET_TIMEOUT_EN
   typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE, S_ERR} state_t;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] r_cnt;
`else
   typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;
`endif

   localparam logic [31:0] PC_MASK = (PC_BITS >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << PC_BITS) - 32'd1);

   state_t      r_state, w_next;
   logic [31:0] r_addr;
   logic [31:0] r_frame;
   logic        r_isRti;
   logic        r_first;
   logic        w_req;

   assign w_req = i_isRet | i_isRti;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_addr  <= 32'd0;
         r_frame <= 32'd0;
         r_isRti <= 1'b0;
         r_first <= 1'b0;
`ifdef RET_TIMEOUT_EN
         r_cnt   <= '0;
`endif
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_addr  <= i_sp + 32'd2;
                  r_isRti <= i_isRti;
                  r_first <= 1'b1;
`ifdef RET_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
               end
            end
            S_READ: begin
               r_first <= 1'b0;
               if (i_memValid) begin
                  r_frame <= i_memData;
               end
`ifdef RET_TIMEOUT_EN
               else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
`endif
            end
            default: ;
         endcase
      end
   end

   // Outputs decode from state and registers only; no input reaches an output.
   always_comb begin
      w_next      = r_state;
      o_memRead   = 1'b0;
      o_en32      = 1'b0;
      o_spPop     = 1'b0;
      o_stall     = 1'b0;
      o_pcLoad    = 1'b0;
      o_flagsLoad = 1'b0;
      o_flush     = 1'b0;
      o_timeout   = 1'b0;
      o_address   = r_addr;
      o_pc        = r_frame & PC_MASK;
      o_flags     = r_frame[31:28];
      case (r_state)
         S_IDLE: begin
            if (w_req) w_next = S_READ;
         end
         S_READ: begin
            o_memRead = 1'b1;
            o_en32    = 1'b1;
            o_stall   = 1'b1;
            o_spPop   = r_first;
            if (i_memValid) w_next = S_DONE;
`ifdef RET_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TIMEOUT - 1)) w_next = S_ERR;
`endif
         end
         S_DONE: begin
            o_pcLoad    = 1'b1;
            o_flush     = 1'b1;
            o_flagsLoad = r_isRti;
            w_next      = S_IDLE;
         end
`ifdef RET_TIMEOUT_EN
         S_ERR: begin
            o_timeout = 1'b1;
            w_next    = S_IDLE;
         end
`endif
         default: w_next = S_IDLE;
      endcase
   end

endmodule
